// File: rtl/v_ingress_q.sv
// v_ingress_q: staging FIFO in front of the v core.
// Buffers up to N producer entries and presents them to the core in order.
// Wrap-bit pointers plus an explicit occupancy register drive the status outputs.
module v_ingress_q #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic [W-1:0]           in_dat,
    output logic                   in_rdy,
    output logic                   out_vld,
    output logic [W-1:0]           out_dat,
    input  logic                   out_rdy,
    output logic [$clog2(N):0]     occ,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(N);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] OCC_FULL = PW'(N);

    logic [W-1:0]  r_mem [N];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_occ;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    assign w_full  = (r_occ == OCC_FULL);
    assign w_empty = (r_occ == '0);

    assign in_rdy  = rst & ~w_full;
    assign out_vld = ~w_empty;
    assign out_dat = r_mem[r_rd_ptr[AW-1:0]];
    assign occ     = r_occ;
    assign full    = w_full;
    assign empty   = w_empty;

    // Pop is additionally gated by rst so a reset cycle never consumes the head.
    assign w_push = in_vld & in_rdy;
    assign w_pop  = out_vld & out_rdy & rst;

    // Storage write on accepted push; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_dat;
        end
    end

    // Pointer and occupancy update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + PW'(1);
                2'b01:   r_occ <= r_occ - PW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Simulation-only consistency checks between occupancy, pointers and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (r_occ <= OCC_FULL) else $error("occ exceeds depth");
            assert (!(w_push && w_full)) else $error("push while full");
            assert (!(w_pop && w_empty)) else $error("pop while empty");
            assert (!(w_full && w_empty)) else $error("full and empty together");
            assert (r_occ == PW'(r_wr_ptr - r_rd_ptr)) else $error("occ disagrees with pointers");
            assert (w_full == ((r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                               (r_wr_ptr[AW] != r_rd_ptr[AW])))
                else $error("full disagrees with pointers");
            assert (w_empty == (r_wr_ptr == r_rd_ptr)) else $error("empty disagrees with pointers");
        end
    end
`endif

endmodule

// File: tb/tb_v_ingress_q.sv
// Bench for v_ingress_q: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_v_ingress_q;

    localparam int W = 32;
    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_vld;
    logic [W-1:0]         in_dat;
    logic                 in_rdy;
    logic                 out_vld;
    logic [W-1:0]         out_dat;
    logic                 out_rdy;
    logic [$clog2(N):0]   occ;
    logic                 full;
    logic                 empty;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_q[$];
    bit           model_ok = 1'b0;

    v_ingress_q #(.W(W), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_dat  (in_dat),
        .in_rdy  (in_rdy),
        .out_vld (out_vld),
        .out_dat (out_dat),
        .out_rdy (out_rdy),
        .occ     (occ),
        .full    (full),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next falling edge; inputs are driven and
    // literal expectations checked from here.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: a plain queue updated at every rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            model_q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            bit do_push;
            bit do_pop;
            do_push = in_vld && (model_q.size() < N);
            do_pop  = out_rdy && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_dat);
        end
    end

    // Compare DUT outputs against the model every cycle after the first reset.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_in_rdy",  64'(in_rdy),  64'(rst && (model_q.size() < N)));
            chk("m_out_vld", 64'(out_vld), 64'(model_q.size() > 0));
            chk("m_occ",     64'(occ),     64'(model_q.size()));
            chk("m_full",    64'(full),    64'(model_q.size() == N));
            chk("m_empty",   64'(empty),   64'(model_q.size() == 0));
            if (model_q.size() > 0) chk("m_out_dat", 64'(out_dat), 64'(model_q[0]));
        end
    end

    initial begin
        rst = 1'b0; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0;

        // 1. Reset then idle
        for (int i = 0; i < 3; i++) tick();
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        rst = 1'b1;
        tick();
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_empty",   64'(empty),   64'd1);
        chk("rst_full",    64'(full),    64'd0);
        chk("rst_occ",     64'(occ),     64'd0);
        chk("rst_in_rdy1", 64'(in_rdy),  64'd1);

        // 2. Fill and drain
        for (int i = 0; i < 4; i++) begin
            in_vld = 1'b1; in_dat = 32'hA0 + 32'(i);
            tick();
        end
        chk("fill_occ",    64'(occ),    64'd4);
        chk("fill_full",   64'(full),   64'd1);
        chk("fill_in_rdy", 64'(in_rdy), 64'd0);
        in_dat = 32'hEE;
        tick();
        chk("fill_ignore_occ", 64'(occ),     64'd4);
        chk("fill_head",       64'(out_dat), 64'hA0);
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_vld", 64'(out_vld), 64'd1);
            chk("drain_dat", 64'(out_dat), 64'(32'hA0 + 32'(i)));
            tick();
        end
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_occ",   64'(occ),   64'd0);

        // 3. Latency: no bypass when empty
        in_vld = 1'b1; in_dat = 32'h55; out_rdy = 1'b1;
        chk("lat_before", 64'(out_vld), 64'd0);
        tick();
        chk("lat_vld", 64'(out_vld), 64'd1);
        chk("lat_dat", 64'(out_dat), 64'h55);
        in_vld = 1'b0;
        tick();
        chk("lat_popped", 64'(out_vld), 64'd0);

        // 4. Streaming at occ=2 across several pointer wraps
        out_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_vld = 1'b1; in_dat = 32'h100 + 32'(i);
            tick();
        end
        out_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_dat = 32'h102 + 32'(i);
            chk("stream_occ", 64'(occ),     64'd2);
            chk("stream_dat", 64'(out_dat), 64'(32'h100 + 32'(i)));
            tick();
        end
        in_vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stream_tail", 64'(out_dat), 64'(32'h114 + 32'(i)));
            tick();
        end
        chk("stream_empty", 64'(empty), 64'd1);

        // 5. Full with simultaneous pop: pop only, push next cycle
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_vld = 1'b1; in_dat = 32'hB0 + 32'(i);
            tick();
        end
        in_dat = 32'hB4; out_rdy = 1'b1;
        chk("fp_in_rdy0", 64'(in_rdy), 64'd0);
        tick();
        chk("fp_occ3",    64'(occ),     64'd3);
        chk("fp_head",    64'(out_dat), 64'hB1);
        chk("fp_in_rdy1", 64'(in_rdy),  64'd1);
        out_rdy = 1'b0;
        tick();
        chk("fp_occ4", 64'(occ), 64'd4);
        in_vld = 1'b0;

        // 6. Reset mid-stream at occ=3
        out_rdy = 1'b1;
        tick();
        chk("mr_occ3", 64'(occ), 64'd3);
        out_rdy = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_occ0",  64'(occ),     64'd0);
        chk("mr_vld0",  64'(out_vld), 64'd0);
        in_vld = 1'b1; in_dat = 32'h77;
        tick();
        in_vld = 1'b0;
        chk("mr_vld1", 64'(out_vld), 64'd1);
        chk("mr_head", 64'(out_dat), 64'h77);
        chk("mr_occ1", 64'(occ),     64'd1);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 99) != 0);
            in_vld  = ($urandom_range(0, 99) < 60);
            out_rdy = ($urandom_range(0, 99) < 50);
            in_dat  = $urandom;
            tick();
        end
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
